// File: rtl/ppu_reg_dbuf.sv
// Shadow/active double buffer for CPU-written PPU control registers.
// Shadow copies commit to the active copy at vblank once the CPU is not mid-update.
module ppu_reg_dbuf #(
    parameter int                  NUM_REGS = 4,
    parameter int                  REG_W    = 32,
    parameter logic [NUM_REGS-1:0] IMM_MASK = '0,
    parameter int                  SKIP_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REGS-1:0]       cpu_wr_valid,
    input  logic [NUM_REGS*REG_W-1:0] cpu_wr_data,
    input  logic                      cpu_wr_busy,
    input  logic                      vblank_start,
    input  logic                      vblank_end_soon,
    output logic [NUM_REGS*REG_W-1:0] act_data,
    output logic [NUM_REGS-1:0]       pending,
    output logic                      commit_done,
    output logic [SKIP_W-1:0]         skip_cnt,
    output logic [1:0]                dbg_state
);

    // Handshake: cpu_wr_valid[i] is a single-cycle strobe with no back-pressure;
    // the block always accepts a write in the cycle it is strobed.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic                        commit_en;
    logic                        skip_inc;
    logic [NUM_REGS*REG_W-1:0]   shadow;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In WAIT a busy drop takes priority over vblank_end_soon in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (vblank_start) begin
                    state_nxt = cpu_wr_busy ? WAIT : COMMIT;
                end
            end
            WAIT: begin
                if (!cpu_wr_busy) begin
                    state_nxt = COMMIT;
                end else if (vblank_end_soon) begin
                    state_nxt = IDLE;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        commit_en = 1'b0;
        skip_inc  = 1'b0;
        case (state)
            WAIT:    skip_inc  = cpu_wr_busy && vblank_end_soon;
            COMMIT:  commit_en = 1'b1;
            default: begin
                commit_en = 1'b0;
                skip_inc  = 1'b0;
            end
        endcase
    end

    // A write landing in the COMMIT cycle re-arms pending; the commit itself
    // transfers the shadow value that was present before that write.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_data    <= '0;
            shadow      <= '0;
            pending     <= '0;
            commit_done <= 1'b0;
            skip_cnt    <= '0;
        end else begin
            commit_done <= commit_en;
            if (skip_inc && (skip_cnt != {SKIP_W{1'b1}})) begin
                skip_cnt <= skip_cnt + 1'b1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (IMM_MASK[i]) begin
                    if (cpu_wr_valid[i]) begin
                        act_data[i*REG_W +: REG_W] <= cpu_wr_data[i*REG_W +: REG_W];
                    end
                end else begin
                    if (commit_en && pending[i]) begin
                        act_data[i*REG_W +: REG_W] <= shadow[i*REG_W +: REG_W];
                    end
                    if (cpu_wr_valid[i]) begin
                        shadow[i*REG_W +: REG_W] <= cpu_wr_data[i*REG_W +: REG_W];
                        pending[i]               <= 1'b1;
                    end else if (commit_en) begin
                        pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
